// File: rtl/heater_drive_ctrl_if.sv
// Bundles the run-request, heater-word and result signals of heater_drive_ctrl.
// The master drives the requests and reg_1; the slave (controller) drives the results.
interface heater_drive_ctrl_if #(
    parameter int PHASE_W = 8
);
    logic               start;
    logic               abort;
    logic [PHASE_W-1:0] duty;
    logic [15:0]        periods;
    logic [31:0]        reg_0;
    logic [31:0]        reg_1;
    logic               busy;
    logic               done;
    logic               aborted;
    logic [31:0]        on_cycles;
    logic [31:0]        status_snap;

    modport master (
        output start, abort, duty, periods, reg_1,
        input  reg_0, busy, done, aborted, on_cycles, status_snap
    );

    modport slave (
        input  start, abort, duty, periods, reg_1,
        output reg_0, busy, done, aborted, on_cycles, status_snap
    );
endinterface

// File: rtl/heater_drive_ctrl.sv
// PWM heater drive: runs `periods` PWM periods at `duty`, settles, then snapshots
// the heater status word. Every output is a flop; abort and reset cut a run short.
module heater_drive_ctrl #(
    parameter int PHASE_W       = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input logic              Clk,
    input logic              Reset,
    heater_drive_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HEAT, SETTLE} state_t;

    localparam logic [PHASE_W-1:0] PHASE_MAX   = '1;
    localparam logic [7:0]         SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t             state, state_next;
    logic [PHASE_W-1:0] phase, phase_inc, duty_q;
    logic [15:0]        periods_left;
    logic [7:0]         settle_cnt;
    logic               heat_en, busy_q, done_q, aborted_q;
    logic [31:0]        on_cycles_q, status_snap_q;
    logic               accept, zero_run, run_abort, settle_end, last_wrap;

    assign phase_inc = phase + 1'b1;
    assign last_wrap = (phase == PHASE_MAX) && (periods_left == 16'd1);

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        zero_run   = 1'b0;
        run_abort  = 1'b0;
        settle_end = 1'b0;
        case (state)
            IDLE: begin
                // abort wins over a simultaneous start
                if (bus.start && !bus.abort) begin
                    if (bus.periods != 16'd0) begin
                        accept     = 1'b1;
                        state_next = HEAT;
                    end else begin
                        zero_run = 1'b1;
                    end
                end
            end
            HEAT: begin
                if (bus.abort) begin
                    run_abort  = 1'b1;
                    state_next = IDLE;
                end else if (last_wrap) begin
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (bus.abort) begin
                    run_abort  = 1'b1;
                    state_next = IDLE;
                end else if (settle_cnt == SETTLE_LAST) begin
                    settle_end = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    // heat_en is computed one cycle ahead so reg_0[0] tracks (phase < duty) as a flop
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            phase         <= '0;
            duty_q        <= '0;
            periods_left  <= '0;
            settle_cnt    <= '0;
            heat_en       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
            on_cycles_q   <= '0;
            status_snap_q <= '0;
        end else begin
            done_q <= zero_run | run_abort | settle_end;
            busy_q <= (state_next != IDLE);
            if (heat_en && on_cycles_q != '1)
                on_cycles_q <= on_cycles_q + 32'd1;

            if (accept) begin
                duty_q       <= bus.duty;
                periods_left <= bus.periods;
                phase        <= '0;
                on_cycles_q  <= '0;
                aborted_q    <= 1'b0;
                heat_en      <= (bus.duty != '0);
            end else if (zero_run) begin
                on_cycles_q <= '0;
                aborted_q   <= 1'b0;
                heat_en     <= 1'b0;
            end else if (run_abort) begin
                heat_en   <= 1'b0;
                aborted_q <= 1'b1;
            end else if (state == HEAT) begin
                phase <= phase_inc;
                if (phase == PHASE_MAX)
                    periods_left <= periods_left - 16'd1;
                if (last_wrap) begin
                    heat_en    <= 1'b0;
                    settle_cnt <= '0;
                end else begin
                    heat_en <= (phase_inc < duty_q);
                end
            end else if (state == SETTLE) begin
                settle_cnt <= settle_cnt + 8'd1;
                if (settle_end)
                    status_snap_q <= bus.reg_1;
            end
        end
    end

    assign bus.reg_0       = {31'b0, heat_en};
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.aborted     = aborted_q;
    assign bus.on_cycles   = on_cycles_q;
    assign bus.status_snap = status_snap_q;
endmodule

// File: doc/heater_drive_ctrl.md
HEATER_DRIVE_CTRL -- requirements
Module: heater_drive_ctrl

Interface
REQ-001 Parameter PHASE_W, default 8, meaning PWM phase counter width; PWM period = 2^PHASE_W cycles.
REQ-002 Parameter SETTLE_CYCLES, default 4, meaning idle cycles after heating before reg_1 is sampled; legal range 1..255.
REQ-003 Port Clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 Port Reset  input  1  asynchronous, active-high reset.
REQ-005 Port start  input  1  single-cycle request to begin a heat run.
REQ-006 Port abort  input  1  single-cycle request to terminate a run.
REQ-007 Port duty  input  PHASE_W  on-cycles per PWM period; sampled only on accepted start.
REQ-008 Port periods  input  16  number of PWM periods to run; sampled only on accepted start.
REQ-009 Port reg_0  output  32  heater control word: bit0 = heater enable; bits[31:1] are tied to 0.
REQ-010 Port reg_1  input  32  heater status word from the heater core.
REQ-011 Port busy  output  1  high while in HEAT or SETTLE.
REQ-012 Port done  output  1  one-cycle pulse on run completion, abort, or zero-length run.
REQ-013 Port aborted  output  1  sticky flag set by abort and cleared on the next accepted start.
REQ-014 Port on_cycles  output  32  count of cycles with reg_0[0]=1 in the current or last run.
REQ-015 Port status_snap  output  32  reg_1 value captured at the end of SETTLE.

Function
REQ-016 The controller SHALL use the states IDLE, HEAT and SETTLE.
REQ-017 The controller SHALL register every output; there are no combinational paths from inputs to outputs.
REQ-018 In IDLE, a start with periods!=0 SHALL be accepted: latch duty and periods, clear phase, on_cycles and aborted, and enter HEAT on the next edge.
REQ-019 In IDLE, a start with periods==0 SHALL pulse done on the next cycle, leave reg_0=0, clear on_cycles and aborted, and remain in IDLE.
REQ-020 start SHALL be ignored while busy=1.
REQ-021 If abort and start are both asserted in IDLE in the same cycle, abort SHALL win: no run starts and no done pulse is issued.
REQ-022 In HEAT, reg_0[0] SHALL equal (phase < duty_latched), registered; the first HEAT cycle has phase=0.
REQ-023 The phase counter SHALL wrap from 2^PHASE_W-1 to 0; each wrap completes one period.
REQ-024 HEAT SHALL last exactly periods*2^PHASE_W cycles; after the last period, the controller SHALL enter SETTLE with reg_0[0]=0.
REQ-025 duty=0 SHALL keep reg_0[0] low for the whole run; duty=2^PHASE_W-1 SHALL give high for all but 1 cycle per period.
REQ-026 on_cycles SHALL increment on every cycle where reg_0[0]=1, saturating at 0xFFFFFFFF; a completed run ends with on_cycles = periods*duty.
REQ-027 SETTLE SHALL hold reg_0=0 for SETTLE_CYCLES cycles; on the final SETTLE cycle, the controller SHALL capture reg_1 into status_snap, pulse done on the next cycle, and return to IDLE.
REQ-028 abort in HEAT or SETTLE SHALL force reg_0=0, set aborted, pulse done, and return to IDLE, all on the next edge; status_snap SHALL NOT be updated.
REQ-029 busy SHALL be high exactly while the state is HEAT or SETTLE.
REQ-030 A done pulse SHALL coincide with the first IDLE cycle.

Reset
REQ-031 Reset=1 SHALL immediately (asynchronously) force state=IDLE and all outputs to 0: reg_0, busy, done, aborted, on_cycles, status_snap.
REQ-032 Reset asserted mid-run SHALL discard the run without a done pulse; after Reset deasserts, the first start SHALL be accepted normally.

Verification
REQ-033 duty=64, periods=2, start at cycle 0 -> reg_0[0] high for 64 cycles then low for 192, twice; busy high for 512+4 cycles; done pulse at cycle 517; on_cycles=128.
REQ-034 periods=0, start -> done on the next cycle; busy stays 0; reg_0=0; on_cycles=0.
REQ-035 duty=0 and duty=255, periods=1 -> on_cycles=0 and 255 respectively; reg_0[31:1]=0 throughout.
REQ-036 abort at HEAT cycle 100 (duty=128) -> reg_0=0 on the next edge; aborted=1; done pulses; on_cycles=100; status_snap unchanged.
REQ-037 reg_1 driven to 0xA5A50001 during SETTLE, completed run -> status_snap=0xA5A50001 when done pulses.
REQ-038 Reset asserted mid-HEAT, off a clock edge -> all outputs 0 immediately, no done pulse; a new start after Reset deasserts runs correctly.
